// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor computing
// A - B - bin, LSB first, through one full-subtractor cell and a registered
// borrow. Start/busy/done handshake: start is sampled in IDLE or DONE, busy is
// high while bits are being processed, and done pulses for one cycle with
// diff/bout/overflow valid. Those three outputs hold their value until the
// next completion or reset.
// Optional build macro ADD_MODE_EN adds a 'mode' input (1 = add, 0 = subtract).
// In add mode the cell becomes a full adder, bin acts as carry-in and bout
// reports carry-out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
`ifdef ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
`ifdef ADD_MODE_EN
    logic             mode_q, mode_d;
`endif

    // Cell signals for the current bit
    logic             a0, b0, d_bit, br_next;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Single full-subtractor (or full-adder) cell plus the final overflow term
    always_comb begin
        a0       = a_q[0];
        b0       = b_q[0];
        d_bit    = a0 ^ b0 ^ br_q;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        // Signed overflow: operands of opposite sign and the result's sign
        // differs from the minuend's
        ovf_next = 1'b0;
`ifdef ADD_MODE_EN
        if (mode_q) begin
            br_next = (a0 & b0) | ((a0 ^ b0) & br_q);
        end
`endif
        res_next = {d_bit, res_q[WIDTH-1:1]};
        ovf_next = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`ifdef ADD_MODE_EN
        // Addition overflows only when both operands share a sign
        if (mode_q) begin
            ovf_next = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
`endif
    end

    // Next-state and datapath control; every _d defaults to hold
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
`ifdef ADD_MODE_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`ifdef ADD_MODE_EN
                    mode_d  = mode;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // start is deliberately ignored here: no restart, no queuing
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_next;
                    bout_d  = br_next;
                    ovf_d   = ovf_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and registered outputs; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADD_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
`ifdef ADD_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with hand-computed results for
// serial_subtractor (WIDTH=8). Expected {diff, bout, overflow} and the cycle
// on which done must appear are queued when a start is issued; a monitor pops
// and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin = 1'b0;
`ifdef ADD_MODE_EN
  logic         mode = 1'b0;
`endif
  logic         busy, done, bout, overflow;
  logic [W-1:0] diff;
  logic [1:0]   dbg_state;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  logic [W+1:0] exp_q[$];
  int           cyc_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .bin       (bin),
`ifdef ADD_MODE_EN
    .mode      (mode),
`endif
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every done pulse must match the oldest queued entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(diff), 32'hFFFF_FFFF);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("diff", 32'(diff), 32'(e[W+1:2]));
        check("bout", 32'(bout), 32'(e[1]));
        check("overflow", 32'(overflow), 32'(e[0]));
        check("done_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // driver: call at a negedge; start is sampled on the following posedge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input bit push);
    a_in  = a;
    b_in  = b;
    bin   = bi;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({ed, eb, eo});
      cyc_q.push_back(cyc + 1 + W);
    end
    @(negedge clk);
    start = 1'b0;
    // operands must not matter once sampled
    a_in  = W'($urandom_range(0, 255));
    b_in  = W'($urandom_range(0, 255));
    bin   = 1'($urandom_range(0, 1));
  endtask

  // bounded wait for done; leaves caller at the negedge where done is seen
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int bcnt;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 5 - 3, also count busy cycles
    start_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(bcnt), 32'd8);
    check("busy_at_done", 32'(busy), 32'd0);
    check("done_seen_t1", 32'(done), 32'd1);

    // 2: 3 - 5 with a hold check mid-RUN
    @(negedge clk);
    start_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_diff_in_run", 32'(diff), 32'h02);
    check("busy_in_run", 32'(busy), 32'd1);
    wait_done("t2");

    // 3: signed overflow and borrow-in
    @(negedge clk);
    start_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
    wait_done("t3a");
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    wait_done("t3b");
    @(negedge clk);
    start_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
    wait_done("t3c");
    @(negedge clk);
    start_op(8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1, 1'b1);
    wait_done("t3d");

    // 4: start during RUN ignored, then back-to-back start in DONE cycle
    @(negedge clk);
    start_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_done("t4a");
    start_op(8'h09, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done("t4b");

    // 5: asynchronous reset mid-RUN aborts
    @(negedge clk);
    start_op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 11) check("no_done_after_abort", 32'(done), 32'd0);
    end
    start_op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    wait_done("t5");

`ifdef ADD_MODE_EN
    // 6: add mode
    @(negedge clk);
    mode = 1'b1;
    start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done("t6a");
    @(negedge clk);
    start_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_done("t6b");
    mode = 1'b0;
`endif

    repeat (12) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse counterpart of the gate-level full adder. It computes A - B - bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is used where area matters more than latency, and shares the operand and borrow conventions of the adder chain. The interface is a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
A  input  WIDTH  minuend; sampled with start
B  input  WIDTH  subtrahend; sampled with start
bin  input  1  borrow-in; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  result A - B - bin mod 2^WIDTH
bout  output  1  borrow-out (unsigned A < B + bin)
overflow  output  1  signed overflow of the subtraction

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; internal shift registers, borrow flop and bit counter clear.
  - busy=0, done=0, diff=0, bout=0, overflow=0.
  - Deassertion is synchronous to clk. No extra synchronizer is inside this block.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE with start=1 (edge k):
  - Latch A and B into shift registers; borrow flop <= bin; counter <= 0.
  - Next state is RUN.
- IDLE with start=0: remain in IDLE. DONE with start=0: go to IDLE.
- RUN, one bit per edge, on the current LSBs a0, b0 and borrow br:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result register from the MSB side; shift the operands right; counter++.
- Completion: at edge k+WIDTH (counter = WIDTH-1 processed), in the same edge:
  - Copy the result register to diff and br_next to bout.
  - overflow <= (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), using the latched operand sign bits.
  - Next state is DONE.
- Latency: done is high for exactly one cycle, in the cycle after edge k+WIDTH (WIDTH edges after the start-sample edge).
- busy is high in cycles after edges k .. k+WIDTH-1.
- diff, bout and overflow hold their previous values during RUN. They change only at completion or reset.
- start during RUN is ignored: no restart and no queuing.
- start in the DONE cycle is accepted (back-to-back operation). done still drops after that one cycle.
- Input changes on A, B and bin after the start-sample edge have no effect.
- rst_n asserted mid-RUN aborts immediately: all outputs go to 0 and no done pulse is issued.

Optional Feature:
Macro ADD_MODE_EN.
- Defined:
  - Extra input port mode (1 bit), sampled with start: 0 = subtract, 1 = add.
  - In add mode the cell is a full adder: d = a0 ^ b0 ^ c; c_next = (a0 & b0) | ((a0 ^ b0) & c).
  - bin acts as cin and bout reports carry-out.
  - overflow <= (A[MSB] == B[MSB]) && (diff[MSB] != A[MSB]).
  - Timing and handshake are identical to subtract mode.
- Undefined: no mode port exists, and the block only subtracts.

Test Plan:
1. WIDTH=8, A=0x05, B=0x03, bin=0, pulse start. Expect busy high for 8 cycles, then done pulses 8 edges after the sample edge with diff=0x02, bout=0, overflow=0.
2. A=0x03, B=0x05, bin=0. Expect diff=0xFE, bout=1, overflow=0.
3. A=0x80, B=0x01, bin=0. Expect diff=0x7F, bout=0, overflow=1. Then A=0x00, B=0x00, bin=1: expect diff=0xFF, bout=1, overflow=0.
4. Start A=0x10, B=0x01. Pulse start with A=0xFF at RUN cycle 3. Expect the first operation to complete with diff=0x0F and no second done pulse. Then start again in the DONE cycle with A=0x09, B=0x09: expect done after 8 more edges with diff=0x00, bout=0.
5. Start A=0x55, B=0x22. Drop rst_n asynchronously at RUN cycle 4. Expect busy, done, diff, bout and overflow all 0 immediately and no done pulse afterward. Release reset and start again with the same operands: expect diff=0x33.
6. With ADD_MODE_EN defined: mode=1, A=0xFF, B=0x01, bin=0 gives diff=0x00, bout=1, overflow=0. Then mode=1, A=0x7F, B=0x01 gives diff=0x80, overflow=1.
